mc_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the RV32I core: steps each instruction through fetch, decode, execute, memory and write-back phases over a single shared memory port. It gates the write enables produced by the combinational control unit (register file, PC, IR, memory), so the datapath can run multi-cycle against a memory with wait states. It also counts retired instructions and enters a sticky trap on an illegal opcode or a memory timeout.

---
 rtl/mc_sequencer.sv | 157 +++++++++++++++
 tb/tb_mc_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I instruction sequencer: walks fetch/decode/execute/memory/write-back
// over one shared memory port, gates datapath write enables, counts retires, traps on faults.
module mc_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    input  logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        reg_we,
    output logic        retire,
    output logic        trap,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t        st;
    state_t        nxt;
    logic [CW-1:0] wait_cnt;
    logic          is_load;
    logic          is_store;
    logic          is_branch;
    logic          is_auipc;
    logic          legal;
    logic          timeout_hit;

    assign state = st;

    always_comb begin
        is_load     = (opcode == OP_LOAD);
        is_store    = (opcode == OP_STORE);
        is_branch   = (opcode == OP_BR);
        is_auipc    = (opcode == OP_AUIPC);
        legal       = 1'b0;
        if (opcode[1:0] == 2'b11) begin
            case (opcode[6:2])
                5'b00000, 5'b01000, 5'b11000, 5'b00100,
                5'b01100, 5'b01101, 5'b00101: legal = 1'b1;
                default:                      legal = 1'b0;
            endcase
        end
        // Only reachable while mem_ready is low; a ready in the same cycle always wins.
        timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_LAST);

        nxt          = st;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        reg_we       = 1'b0;
        retire       = 1'b0;
        trap         = 1'b0;

        case (st)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    nxt   = S_DECODE;
                end else if (timeout_hit) begin
                    nxt = S_TRAP;
                end
            end
            S_DECODE: begin
                if (!stall) nxt = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (!stall) begin
                    if (is_load || is_store) begin
                        nxt = S_MEM;
                    end else if (is_branch) begin
                        pc_we  = 1'b1;
                        pc_src = branch_taken;
                        retire = 1'b1;
                        nxt    = S_FETCH;
                    end else begin
                        nxt = S_WB;
                    end
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                        nxt    = S_FETCH;
                    end else begin
                        nxt = S_WB;
                    end
                end else if (timeout_hit) begin
                    nxt = S_TRAP;
                end
            end
            S_WB: begin
                pc_src = is_auipc;
                if (!stall) begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                    retire = 1'b1;
                    nxt    = S_FETCH;
                end
            end
            S_TRAP: trap = 1'b1;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= S_IDLE;
            wait_cnt <= '0;
            instret  <= '0;
        end else begin
            st <= nxt;
            // Any state change restarts the wait count, so FETCH/MEM always begin at zero.
            if (nxt != st) begin
                wait_cnt <= '0;
            end else if ((st == S_FETCH || st == S_MEM) && !mem_ready) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (retire) instret <= instret + 32'd1;
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed testbench for mc_sequencer: per-cycle output vectors for each instruction class,
// stall, timeout, illegal opcode, counter wrap and asynchronous reset.
module tb_mc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'b0010011;
    logic        branch_taken = 1'b0;
    logic        mem_ready = 1'b0;
    logic        stall = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we, retire, trap;
    logic [2:0]  state;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    // {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we, retire, trap, state}
    wire [11:0] outs = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
                        reg_we, retire, trap, state};

    localparam logic [11:0] IDLE    = 12'h000;
    localparam logic [11:0] F_RDY   = 12'h901;
    localparam logic [11:0] F_WAIT  = 12'h801;
    localparam logic [11:0] DEC     = 12'h002;
    localparam logic [11:0] EXE     = 12'h003;
    localparam logic [11:0] EXE_BT  = 12'h0D3;
    localparam logic [11:0] EXE_BN  = 12'h093;
    localparam logic [11:0] MEM_LD  = 12'hA04;
    localparam logic [11:0] MEM_SW  = 12'hE04;
    localparam logic [11:0] MEM_SR  = 12'hE94;
    localparam logic [11:0] WB      = 12'h0B5;
    localparam logic [11:0] WB_AUI  = 12'h0F5;
    localparam logic [11:0] WB_STL  = 12'h005;
    localparam logic [11:0] TRP     = 12'h00E;

    localparam logic [6:0] ADDI  = 7'b0010011;
    localparam logic [6:0] ADD   = 7'b0110011;
    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] BEQ   = 7'b1100011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;

    mc_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .reg_we(reg_we), .retire(retire), .trap(trap), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        mem_ready = 1'b1;
        opcode = ADDI;
        @(posedge clk);
        #1;
        checks++;
        if (outs !== IDLE) begin errors++; $display("FAIL reset_outs got=%h want=%h", outs, IDLE); end
        checks++;
        if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got=%h want=0", instret); end
        rst_n = 1'b1;
        stall = 1'b1;
        #1;
        checks++;
        if (outs !== IDLE) begin errors++; $display("FAIL reset_idle got=%h want=%h", outs, IDLE); end
        stall = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (outs !== F_RDY) begin errors++; $display("FAIL reset_fetch got=%h want=%h", outs, F_RDY); end
    endtask

    task automatic test_addi();
        logic [21:0] v [5];
        logic [11:0] e;
        v = '{{ADDI, 3'b100, IDLE}, {ADDI, 3'b100, F_RDY}, {ADDI, 3'b100, DEC},
              {ADDI, 3'b100, EXE}, {ADDI, 3'b100, WB}};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            {opcode, mem_ready, stall, branch_taken, e} = v[i];
            #1;
            checks++;
            if (outs !== e) begin errors++; $display("FAIL addi cyc%0d got=%h want=%h", i, outs, e); end
            @(posedge clk);
            #1;
        end
        checks++;
        if (instret !== 32'd1) begin errors++; $display("FAIL addi_instret got=%0d want=1", instret); end
        checks++;
        if (outs !== F_RDY) begin errors++; $display("FAIL addi_refetch got=%h want=%h", outs, F_RDY); end
    endtask

    task automatic test_lw_wait();
        logic [21:0] v [9];
        logic [11:0] e;
        v = '{{LW, 3'b100, IDLE}, {LW, 3'b100, F_RDY}, {LW, 3'b000, DEC}, {LW, 3'b000, EXE},
              {LW, 3'b000, MEM_LD}, {LW, 3'b000, MEM_LD}, {LW, 3'b000, MEM_LD},
              {LW, 3'b100, MEM_LD}, {LW, 3'b100, WB}};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            {opcode, mem_ready, stall, branch_taken, e} = v[i];
            #1;
            checks++;
            if (outs !== e) begin errors++; $display("FAIL lw cyc%0d got=%h want=%h", i, outs, e); end
            @(posedge clk);
            #1;
        end
        checks++;
        if (instret !== 32'd1) begin errors++; $display("FAIL lw_instret got=%0d want=1", instret); end
    endtask

    task automatic test_store();
        logic [21:0] v [7];
        logic [11:0] e;
        v = '{{SW, 3'b100, IDLE}, {SW, 3'b100, F_RDY}, {SW, 3'b000, DEC}, {SW, 3'b000, EXE},
              {SW, 3'b000, MEM_SW}, {SW, 3'b100, MEM_SR}, {SW, 3'b100, F_RDY}};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            {opcode, mem_ready, stall, branch_taken, e} = v[i];
            #1;
            checks++;
            if (outs !== e) begin errors++; $display("FAIL sw cyc%0d got=%h want=%h", i, outs, e); end
            @(posedge clk);
            #1;
        end
        checks++;
        if (instret !== 32'd1) begin errors++; $display("FAIL sw_instret got=%0d want=1", instret); end
    endtask

    task automatic test_branch();
        logic [21:0] v [8];
        logic [11:0] e;
        v = '{{BEQ, 3'b101, IDLE}, {BEQ, 3'b101, F_RDY}, {BEQ, 3'b101, DEC}, {BEQ, 3'b101, EXE_BT},
              {BEQ, 3'b100, F_RDY}, {BEQ, 3'b100, DEC}, {BEQ, 3'b100, EXE_BN}, {BEQ, 3'b100, F_RDY}};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            {opcode, mem_ready, stall, branch_taken, e} = v[i];
            #1;
            checks++;
            if (outs !== e) begin errors++; $display("FAIL beq cyc%0d got=%h want=%h", i, outs, e); end
            @(posedge clk);
            #1;
        end
        checks++;
        if (instret !== 32'd2) begin errors++; $display("FAIL beq_instret got=%0d want=2", instret); end
    endtask

    task automatic test_u_types();
        logic [21:0] v [9];
        logic [11:0] e;
        v = '{{AUIPC, 3'b100, IDLE}, {AUIPC, 3'b100, F_RDY}, {AUIPC, 3'b100, DEC},
              {AUIPC, 3'b100, EXE}, {AUIPC, 3'b100, WB_AUI}, {LUI, 3'b100, F_RDY},
              {LUI, 3'b100, DEC}, {LUI, 3'b100, EXE}, {LUI, 3'b100, WB}};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            {opcode, mem_ready, stall, branch_taken, e} = v[i];
            #1;
            checks++;
            if (outs !== e) begin errors++; $display("FAIL utype cyc%0d got=%h want=%h", i, outs, e); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stall();
        logic [21:0] v [10];
        logic [11:0] e;
        v = '{{ADD, 3'b100, IDLE}, {ADD, 3'b110, F_RDY}, {ADD, 3'b110, DEC}, {ADD, 3'b100, DEC},
              {ADD, 3'b110, EXE}, {ADD, 3'b100, EXE}, {ADD, 3'b110, WB_STL}, {ADD, 3'b110, WB_STL},
              {ADD, 3'b100, WB}, {ADD, 3'b100, F_RDY}};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            {opcode, mem_ready, stall, branch_taken, e} = v[i];
            #1;
            checks++;
            if (outs !== e) begin errors++; $display("FAIL stall cyc%0d got=%h want=%h", i, outs, e); end
            @(posedge clk);
            #1;
        end
        checks++;
        if (instret !== 32'd1) begin errors++; $display("FAIL stall_instret got=%0d want=1", instret); end
    endtask

    task automatic test_illegal();
        logic [6:0] bad [3];
        bad = '{7'b0000000, 7'b0010001, 7'b1110011};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            opcode = bad[k];
            mem_ready = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            checks++;
            if (outs !== DEC) begin errors++; $display("FAIL illegal%0d_dec got=%h want=%h", k, outs, DEC); end
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                opcode = ADDI;
                checks++;
                if (outs !== TRP) begin errors++; $display("FAIL illegal%0d_trap%0d got=%h want=%h", k, i, outs, TRP); end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        opcode = ADDI;
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) begin
            #1;
            checks++;
            if (outs !== F_WAIT) begin errors++; $display("FAIL tmo_wait%0d got=%h want=%h", i, outs, F_WAIT); end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== TRP) begin errors++; $display("FAIL tmo_trap%0d got=%h want=%h", i, outs, TRP); end
            @(posedge clk); #1;
        end
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 14; i++) @(posedge clk);
        #1;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (outs !== F_RDY) begin errors++; $display("FAIL tmo_last_ready got=%h want=%h", outs, F_RDY); end
        @(posedge clk); #1;
        checks++;
        if (outs !== DEC) begin errors++; $display("FAIL tmo_no_trap got=%h want=%h", outs, DEC); end
    endtask

    task automatic test_wrap_and_async_reset();
        do_reset();
        opcode = BEQ;
        mem_ready = 1'b1;
        branch_taken = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        @(posedge clk); #1;
        checks++;
        if (outs !== EXE_BN || instret !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL wrap_pre outs=%h instret=%h want=%h/ffffffff", outs, instret, EXE_BN);
        end
        @(posedge clk); #1;
        checks++;
        if (instret !== 32'd0) begin errors++; $display("FAIL wrap got=%h want=00000000", instret); end

        do_reset();
        opcode = LW;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (outs !== MEM_LD) begin errors++; $display("FAIL async_mem got=%h want=%h", outs, MEM_LD); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== IDLE || instret !== 32'd0) begin
            errors++; $display("FAIL async_drop outs=%h instret=%h want=%h/0", outs, instret, IDLE);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lw_wait();
        test_store();
        test_branch();
        test_u_types();
        test_stall();
        test_illegal();
        test_timeout();
        test_wrap_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
